// File: rtl/maze_grid_writer_if.sv
// Tile-write, clear and renderer-window signals of the maze grid writer.
// The master drives requests and window origin; the slave is the writer.
interface maze_grid_writer_if;
  logic [4:0] maze_width;
  logic [4:0] maze_height;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_x;
  logic [4:0] wr_y;
  logic       wr_bit;
  logic       wr_err;
  logic       clear_req;
  logic       busy;
  logic [4:0] win_x;
  logic [4:0] win_y;
  logic       frame_start;
  logic [8:0] path_data;

  modport master (
    output maze_width, maze_height, wr_valid, wr_x, wr_y, wr_bit,
           clear_req, win_x, win_y, frame_start,
    input  wr_ready, wr_err, busy, path_data
  );

  modport slave (
    input  maze_width, maze_height, wr_valid, wr_x, wr_y, wr_bit,
           clear_req, win_x, win_y, frame_start,
    output wr_ready, wr_err, busy, path_data
  );
endinterface

// File: rtl/maze_grid_writer.sv
// Bit-per-tile maze grid with a write port, a row-at-a-time clear sequencer
// and a 3x3 window latched for the renderer at frame boundaries.
module maze_grid_writer #(
  parameter int MAX_DIM = 20
) (
  input  logic               clk,
  input  logic               reset,
  maze_grid_writer_if.slave  bus
);
  localparam int            IW       = $clog2(MAX_DIM);
  localparam logic [5:0]    DIM6     = 6'(MAX_DIM);
  localparam logic [IW-1:0] LAST_ROW = IW'(MAX_DIM - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      row_q, row_d;
  logic               pend_q, pend_d;
  logic [8:0]         path_q, path_d;
  logic               wr_err_q, wr_err_d;
  logic [MAX_DIM-1:0] grid_q [MAX_DIM];
  logic [MAX_DIM-1:0] grid_d [MAX_DIM];

  logic       wr_fire;
  logic       wr_in_range;
  logic       sample;
  logic [8:0] win_bits;

  assign bus.wr_ready  = (state_q == IDLE) && !bus.clear_req;
  assign bus.busy      = (state_q == CLEAR);
  assign bus.wr_err    = wr_err_q;
  assign bus.path_data = path_q;

  assign wr_fire     = bus.wr_valid && bus.wr_ready;
  assign wr_in_range = (bus.wr_x < bus.maze_width) && (bus.wr_y < bus.maze_height) &&
                       ({1'b0, bus.wr_x} < DIM6) && ({1'b0, bus.wr_y} < DIM6);
  // A frame request seen during a clear is replayed on the first idle cycle.
  assign sample      = (state_q == IDLE) && (bus.frame_start || pend_q);

  // Window sums are 6 bits wide so an origin near 31 never wraps to column 0.
  always_comb begin
    logic [5:0] col;
    logic [5:0] row;
    win_bits = '0;
    col      = '0;
    row      = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        col = {1'b0, bus.win_x} + 6'(i);
        row = {1'b0, bus.win_y} + 6'(j);
        if ((col < {1'b0, bus.maze_width}) && (row < {1'b0, bus.maze_height}) &&
            (col < DIM6) && (row < DIM6))
          win_bits[3*i+j] = grid_q[row[IW-1:0]][col[IW-1:0]];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    pend_d   = pend_q;
    path_d   = path_q;
    wr_err_d = 1'b0;
    grid_d   = grid_q;

    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          row_d   = '0;
        end
      end
      CLEAR: begin
        grid_d[row_q] = '0;
        if (bus.frame_start)
          pend_d = 1'b1;
        if (row_q == LAST_ROW) begin
          state_d = IDLE;
          row_d   = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
    endcase

    if (wr_fire) begin
      if (wr_in_range)
        grid_d[bus.wr_y[IW-1:0]][bus.wr_x[IW-1:0]] = bus.wr_bit;
      else
        wr_err_d = 1'b1;
    end

    if (sample) begin
      path_d = win_bits;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      pend_q   <= 1'b0;
      path_q   <= '0;
      wr_err_q <= 1'b0;
      grid_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      pend_q   <= pend_d;
      path_q   <= path_d;
      wr_err_q <= wr_err_d;
      grid_q   <= grid_d;
    end
  end
endmodule

// File: doc/maze_grid_writer.md
MAZE_GRID_WRITER -- requirements
Module: maze_grid_writer

Interface
REQ-001 Parameter: MAX_DIM, default 20, maximum maze width/height in tiles; grid storage is MAX_DIM x MAX_DIM bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (name kept as "reset"; low = in reset).
REQ-004 Port: maze_width  input  5  active maze width in tiles, legal 1..MAX_DIM.
REQ-005 Port: maze_height  input  5  active maze height in tiles, legal 1..MAX_DIM.
REQ-006 Port: wr_valid  input  1  tile-write request.
REQ-007 Port: wr_ready  output  1  writer can accept a tile write this cycle.
REQ-008 Port: wr_x  input  5  tile column of write.
REQ-009 Port: wr_y  input  5  tile row of write.
REQ-010 Port: wr_bit  input  1  path value (1 = path tile).
REQ-011 Port: wr_err  output  1  one-cycle pulse, accepted write was out of range and discarded.
REQ-012 Port: clear_req  input  1  request to zero the whole grid.
REQ-013 Port: busy  output  1  high while clearing.
REQ-014 Port: win_x  input  5  window origin column for renderer readout.
REQ-015 Port: win_y  input  5  window origin row for renderer readout.
REQ-016 Port: frame_start  input  1  one-cycle pulse at start of vertical blanking; window update point.
REQ-017 Port: path_data  output  9  3x3 tile window for the maze renderer.

Function
REQ-018 FSM states: IDLE, CLEAR; IDLE -> CLEAR when clear_req=1; CLEAR -> IDLE after row counter reaches MAX_DIM-1.
REQ-019 CLEAR zeroes one full grid row per cycle, rows 0..MAX_DIM-1 in order; clear duration exactly MAX_DIM cycles; busy=1 exactly while state=CLEAR.
REQ-020 wr_ready = (state==IDLE) && !clear_req; combinational.
REQ-021 Write accepted when wr_valid && wr_ready; cell(wr_x,wr_y) <= wr_bit at that edge, visible to window sampling on the next cycle.
REQ-022 Accepted write with wr_x >= maze_width or wr_y >= maze_height: grid unchanged, wr_err=1 for the following cycle only.
REQ-023 clear_req and wr_valid same cycle: clear wins, write not accepted, wr_valid must be held by source.
REQ-024 clear_req during CLEAR ignored (no restart).
REQ-025 Window packing: path_data[3*i+j] = cell(win_x+i, win_y+j), i = column offset 0..2, j = row offset 0..2.
REQ-026 Window cell with column >= maze_width, row >= maze_height, or index >= MAX_DIM reads 0; index sums computed 6-bit, no wrap-around.
REQ-027 frame_start in IDLE: win_x/win_y and grid sampled that cycle; path_data updates at that edge (1-cycle latency) and holds until next sample.
REQ-028 frame_start in CLEAR: sample deferred via pending flag; sample taken in first IDLE cycle after CLEAR, then pending cleared.
REQ-029 Multiple frame_start pulses during one CLEAR yield a single deferred sample.
REQ-030 path_data never changes except at a sample edge; writes do not alter path_data mid-frame.

Reset
REQ-031 reset low: grid all 0, state IDLE, row counter 0, pending 0, path_data 9'b0, wr_err 0, busy 0, asynchronously.
REQ-032 reset asserted mid-CLEAR or mid-write aborts operation; after release, block in IDLE with wr_ready=1 absent clear_req.

Verification
REQ-033 Reset release, maze 3x3, write (1,2)=1, frame_start, win=(0,0) -> next cycle path_data=9'b000100000 (bit 5).
REQ-034 Write (1,1)=1 with no frame_start -> path_data unchanged; after frame_start -> bit 4 set.
REQ-035 maze_width=3, write (3,0)=1 -> wr_err pulses one cycle, grid unchanged, later window (1,0) bit 6 = 0.
REQ-036 clear_req with wr_valid same cycle -> wr_ready=0, busy=1 for 20 cycles (MAX_DIM=20), all path_data bits 0 after next frame_start.
REQ-037 frame_start twice during CLEAR -> exactly one path_data update, in first cycle after busy falls.
REQ-038 reset low during CLEAR cycle 5 -> path_data=0, busy=0 immediately; after release wr_ready=1.
